adc_pattern_gen: RTL and testbench

Test-pattern transmitter for the Red Pitaya ADC capture path. It drives a `DATA_WIDTH`-bit parallel word each clock, in place of live ADC samples, for bring-up and self-test of the capture core. It first sends an alternating all-zeros/all-ones lock preamble, which the capture-side pattern validator accepts after `2^CNT_WIDTH` matching words. It then sends a selectable payload pattern, with optional single-word error injection for exercising validator loss-of-lock.

---
 rtl/adc_pattern_gen.sv | 151 +++++++++++++++
 tb/tb_adc_pattern_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pattern_gen.sv
// ADC test-pattern transmitter: lock preamble (alternating 0/all-ones, 2^CNT_WIDTH words), then a selectable payload.
// Latency: all outputs registered, one cycle from inputs; no backpressure. Define ADC_PATGEN_PRBS_EN to build the PRBS-15 payload.
module adc_pattern_gen #(
    parameter int DATA_WIDTH = 14,
    parameter int CNT_WIDTH  = 17
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic                  inject_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  preamble_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            mode_q, mode_d;
    logic                  inj_q, inj_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  pre_q, pre_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] pat;

`ifdef ADC_PATGEN_PRBS_EN
    localparam logic [14:0] LFSR_SEED = 15'h7FFF;
    localparam int          LW        = (DATA_WIDTH < 15) ? DATA_WIDTH : 15;

    logic [14:0] lfsr_q, lfsr_d;

    // x^15 + x^14 + 1, shifting towards the MSB
    function automatic logic [14:0] lfsr_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction
`endif

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 2'd0;
            inj_q   <= 1'b0;
            data_q  <= '0;
            pre_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADC_PATGEN_PRBS_EN
            lfsr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            inj_q   <= inj_d;
            data_q  <= data_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
`ifdef ADC_PATGEN_PRBS_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        inj_d   = 1'b0;
        pre_d   = 1'b0;
        done_d  = 1'b0;
        pat     = '0;
`ifdef ADC_PATGEN_PRBS_EN
        lfsr_d  = lfsr_q;
`endif

        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
`ifdef ADC_PATGEN_PRBS_EN
            lfsr_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PRE;
                    cnt_d   = '0;
                    mode_d  = mode_i;
                    pre_d   = 1'b1;
                end
                PRE: begin
                    inj_d = inject_i;
                    // cnt_q tracks the word currently on the output
                    if (cnt_q == '1) begin
                        state_d = RUN;
                        idx_d   = '0;
                        done_d  = 1'b1;
`ifdef ADC_PATGEN_PRBS_EN
                        lfsr_d  = LFSR_SEED;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        pre_d = 1'b1;
                    end
                end
                RUN: begin
                    inj_d  = inject_i;
                    idx_d  = idx_q + 1'b1;
                    done_d = 1'b1;
`ifdef ADC_PATGEN_PRBS_EN
                    lfsr_d = lfsr_step(lfsr_q);
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == PRE) begin
            pat = {DATA_WIDTH{cnt_d[0]}};
        end else if (state_d == RUN) begin
            case (mode_q)
                2'd1:    pat = idx_d;
                2'd3:    pat = '0;
`ifdef ADC_PATGEN_PRBS_EN
                2'd2:    pat = DATA_WIDTH'(lfsr_d[LW-1:0]);
`endif
                default: pat = {DATA_WIDTH{idx_d[0]}};
            endcase
        end

        // inject flips bit 0 of the word after the one it was sampled with
        data_d = pat ^ {{(DATA_WIDTH-1){1'b0}}, inj_q & enable_i};
    end

    assign data_o     = data_q;
    assign preamble_o = pre_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Self-checking bench for adc_pattern_gen (DATA_WIDTH=14, CNT_WIDTH=4) against a word-index reference model.
module tb_adc_pattern_gen;

    localparam int DW      = 14;
    localparam int CW      = 4;
    localparam int PRE_LEN = 1 << CW;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic          inject_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          preamble_o;
    logic          done_o;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit            m_active = 1'b0;
    int            m_t = 0;
    logic [1:0]    m_mode = 2'd0;
    logic          m_inj = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_pre = 1'b0;
    logic          exp_done = 1'b0;

    adc_pattern_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .aclk       (aclk),
        .resetn     (resetn),
        .enable_i   (enable_i),
        .mode_i     (mode_i),
        .inject_i   (inject_i),
        .data_o     (data_o),
        .preamble_o (preamble_o),
        .done_o     (done_o)
    );

    always #5 aclk = ~aclk;

    // word number t counted from the first preamble word
    function automatic logic [DW-1:0] ref_word(input int t, input logic [1:0] md);
        int          j;
        logic [14:0] s;
        if (t < PRE_LEN) return (t % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
        j = t - PRE_LEN;
        s = 15'h7FFF;
        case (md)
            2'd1: return DW'(j % (1 << DW));
            2'd3: return '0;
`ifdef ADC_PATGEN_PRBS_EN
            2'd2: begin
                for (int k = 0; k < j; k++) s = {s[13:0], s[14] ^ s[13]};
                return s[DW-1:0];
            end
`endif
            default: return (j % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
        endcase
    endfunction

    // apply inputs for one edge and advance the model; returns #1 after the edge
    task automatic drive_cycle(input logic rn, input logic en, input logic [1:0] md, input logic inj);
        logic corrupt;
        resetn   = rn;
        enable_i = en;
        mode_i   = md;
        inject_i = inj;
        @(posedge aclk);
        corrupt = 1'b0;
        if (!rn || !en) begin
            m_active = 1'b0;
            m_inj    = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_t      = 0;
            m_mode   = md;
            m_inj    = 1'b0;
        end else begin
            corrupt = m_inj;
            m_t++;
            m_inj = inj;
        end
        exp_data = m_active ? (ref_word(m_t, m_mode) ^ {{(DW-1){1'b0}}, corrupt}) : '0;
        exp_pre  = m_active && (m_t < PRE_LEN);
        exp_done = m_active && (m_t >= PRE_LEN);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 2'd1, 1'b1);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {{DW{1'b0}}, 1'b0, 1'b0}) begin
                $display("FAIL reset cyc=%0d got data=%h pre=%b done=%b want 0/0/0", i, data_o, preamble_o, done_o);
            end else n_pass++;
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
        n_chk++;
        if ({data_o, preamble_o, done_o} !== {{DW{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL idle got data=%h pre=%b done=%b want 0/0/0", data_o, preamble_o, done_o);
        end else n_pass++;
    endtask

    task automatic test_toggle;
        for (int i = 0; i < PRE_LEN + 12; i++) begin
            drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {exp_data, exp_pre, exp_done}) begin
                $display("FAIL toggle t=%0d got %h/%b/%b want %h/%b/%b", m_t, data_o, preamble_o, done_o, exp_data, exp_pre, exp_done);
            end else n_pass++;
            if (i == PRE_LEN - 1 || i == PRE_LEN) begin
                n_chk++;
                if ({data_o, preamble_o, done_o} !== ((i == PRE_LEN) ? {14'h0000, 1'b0, 1'b1} : {14'h3FFF, 1'b1, 1'b0})) begin
                    $display("FAIL toggle_boundary i=%0d got %h/%b/%b", i, data_o, preamble_o, done_o);
                end else n_pass++;
            end
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
        n_chk++;
        if ({data_o, preamble_o, done_o} !== {{DW{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL toggle_disable got %h/%b/%b want 0/0/0", data_o, preamble_o, done_o);
        end else n_pass++;
    endtask

    task automatic test_ramp;
        logic [1:0] md;
        for (int i = 0; i < PRE_LEN + (1 << DW) + 4; i++) begin
            md = (i < 40) ? 2'd1 : 2'($urandom_range(3));
            drive_cycle(1'b1, 1'b1, md, 1'b0);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {exp_data, exp_pre, exp_done}) begin
                $display("FAIL ramp t=%0d got %h/%b/%b want %h/%b/%b", m_t, data_o, preamble_o, done_o, exp_data, exp_pre, exp_done);
            end else n_pass++;
            if (m_t == PRE_LEN + (1 << DW) - 1 || m_t == PRE_LEN + (1 << DW)) begin
                n_chk++;
                if (data_o !== ((m_t == PRE_LEN + (1 << DW)) ? 14'h0000 : 14'h3FFF)) begin
                    $display("FAIL ramp_wrap t=%0d got %h", m_t, data_o);
                end else n_pass++;
            end
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_prbs;
        logic [DW-1:0] w0, w1;
`ifdef ADC_PATGEN_PRBS_EN
        w0 = 14'h3FFF; w1 = 14'h3FFE;
`else
        w0 = 14'h0000; w1 = 14'h3FFF;
`endif
        for (int i = 0; i < PRE_LEN + 40; i++) begin
            drive_cycle(1'b1, 1'b1, 2'd2, 1'b0);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {exp_data, exp_pre, exp_done}) begin
                $display("FAIL prbs t=%0d got %h/%b/%b want %h/%b/%b", m_t, data_o, preamble_o, done_o, exp_data, exp_pre, exp_done);
            end else n_pass++;
            if (m_t == PRE_LEN || m_t == PRE_LEN + 1) begin
                n_chk++;
                if (data_o !== ((m_t == PRE_LEN) ? w0 : w1)) begin
                    $display("FAIL prbs_first t=%0d got %h want %h", m_t, data_o, (m_t == PRE_LEN) ? w0 : w1);
                end else n_pass++;
            end
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    // single-cycle inject landing on word 5, then a 3-cycle held inject in RUN
    task automatic test_inject;
        logic inj;
        for (int i = 0; i < PRE_LEN + 14; i++) begin
            inj = (i == 4) || (i >= 20 && i < 23);
            drive_cycle(1'b1, 1'b1, 2'd0, inj);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {exp_data, exp_pre, exp_done}) begin
                $display("FAIL inject t=%0d got %h/%b/%b want %h/%b/%b", m_t, data_o, preamble_o, done_o, exp_data, exp_pre, exp_done);
            end else n_pass++;
            if (m_t == 5 || m_t == 6) begin
                n_chk++;
                if (data_o !== ((m_t == 5) ? 14'h3FFE : 14'h0000)) begin
                    $display("FAIL inject_word t=%0d got %h", m_t, data_o);
                end else n_pass++;
            end
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_enable_drop;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {{DW{1'b0}}, 1'b0, 1'b0}) begin
                $display("FAIL drop_idle got %h/%b/%b want 0/0/0", data_o, preamble_o, done_o);
            end else n_pass++;
        end
        for (int i = 0; i < PRE_LEN + 4; i++) begin
            drive_cycle(1'b1, 1'b1, 2'd1, 1'b0);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {exp_data, exp_pre, exp_done}) begin
                $display("FAIL restart t=%0d got %h/%b/%b want %h/%b/%b", m_t, data_o, preamble_o, done_o, exp_data, exp_pre, exp_done);
            end else n_pass++;
        end
        drive_cycle(1'b0, 1'b1, 2'd1, 1'b0);
        n_chk++;
        if ({data_o, preamble_o, done_o} !== {{DW{1'b0}}, 1'b0, 1'b0}) begin
            $display("FAIL reset_mid_run got %h/%b/%b want 0/0/0", data_o, preamble_o, done_o);
        end else n_pass++;
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_random;
        logic rn, en, inj;
        logic [1:0] md;
        for (int i = 0; i < 3000; i++) begin
            rn  = ($urandom_range(499) != 0);
            en  = ($urandom_range(79) != 0);
            md  = 2'($urandom_range(3));
            inj = ($urandom_range(9) == 0);
            drive_cycle(rn, en, md, inj);
            n_chk++;
            if ({data_o, preamble_o, done_o} !== {exp_data, exp_pre, exp_done}) begin
                $display("FAIL random i=%0d t=%0d got %h/%b/%b want %h/%b/%b", i, m_t, data_o, preamble_o, done_o, exp_data, exp_pre, exp_done);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_ramp();
        test_prbs();
        test_inject();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
